// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter: opcode map, compare range, FSM states.
package alu_arb_pkg;

  localparam int unsigned NCoresDef = 4;
  localparam int unsigned DataWDef  = 8;

  typedef enum logic [3:0] {
    OpAnd = 4'h0, OpOr, OpNot, OpXor, OpShl, OpShr, OpRol, OpRor,
    OpAdd, OpSub, OpEq, OpGt, OpGe, OpNe, OpLe, OpLt
  } alu_op_e;

  // Compare opcodes occupy the top of the map, from OpEq up to 4'b1111.
  localparam logic [3:0] IsCompareLo = OpEq;

  typedef enum logic [0:0] {StIdle, StExec} alu_arb_state_e;

  function automatic logic is_compare(logic [3:0] op);
    return op >= IsCompareLo;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Core-side request/response bus plus the shared ALU hookup of the arbiter.
interface alu_arbiter_if
  import alu_arb_pkg::*;
#(
  parameter int unsigned N_CORES = NCoresDef,
  parameter int unsigned DATA_W  = DataWDef
);
  logic [N_CORES-1:0]        ARB_Req;
  logic [4*N_CORES-1:0]      ARB_OPCode;
  logic [DATA_W*N_CORES-1:0] ARB_A;
  logic [DATA_W*N_CORES-1:0] ARB_B;
  logic [N_CORES-1:0]        ARB_CmpEn;
  logic [N_CORES-1:0]        ARB_Grant;
  logic [N_CORES-1:0]        ARB_Done;
  logic [DATA_W-1:0]         ARB_Result;
  logic [N_CORES-1:0]        ARB_CmpFlag;
  logic [3:0]                ALU_OPCode;
  logic [DATA_W-1:0]         ALU_A;
  logic [DATA_W-1:0]         ALU_B;
  logic                      ALU_CompEn;
  logic [DATA_W-1:0]         ALU_Result;

  modport slave (
    input  ARB_Req, ARB_OPCode, ARB_A, ARB_B, ARB_CmpEn, ALU_Result,
    output ARB_Grant, ARB_Done, ARB_Result, ARB_CmpFlag,
    output ALU_OPCode, ALU_A, ALU_B, ALU_CompEn
  );

  modport master (
    output ARB_Req, ARB_OPCode, ARB_A, ARB_B, ARB_CmpEn, ALU_Result,
    input  ARB_Grant, ARB_Done, ARB_Result, ARB_CmpFlag,
    input  ALU_OPCode, ALU_A, ALU_B, ALU_CompEn
  );
endinterface

// File: rtl/alu_arb_rr_picker.sv
// Round-robin winner selection over the request vector, with its own rotating pointer.
// Defining ALU_ARB_FIXED_PRIORITY_EN removes the pointer: lowest index always wins.
module alu_arb_rr_picker
  import alu_arb_pkg::*;
#(
  parameter int unsigned N_CORES = NCoresDef,
  parameter int unsigned IdxW    = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_CORES-1:0] req,
  input  logic               advance,
  output logic [N_CORES-1:0] winner,
  output logic [IdxW-1:0]    winner_idx
);
  logic [IdxW-1:0] ptr;
  int unsigned     cand;
  logic            found;

  // Scan from the pointer upward, wrapping, and take the first set request.
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    found      = 1'b0;
    cand       = 0;
    for (int unsigned k = 0; k < N_CORES; k++) begin
      cand = (32'(ptr) + k) % N_CORES;
      if (!found && req[IdxW'(cand)]) begin
        found                  = 1'b1;
        winner[IdxW'(cand)]    = 1'b1;
        winner_idx             = IdxW'(cand);
      end
    end
  end

`ifdef ALU_ARB_FIXED_PRIORITY_EN
  logic unused_rr;
  assign unused_rr = ^{clk, rst_n, advance};
  assign ptr = '0;
`else
  logic [IdxW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (winner_idx == IdxW'(N_CORES - 1)) ? '0 : winner_idx + IdxW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Time-shares one combinational ALU between N_CORES requesters: grant, one execute cycle, done.
// Arbitration order follows ALU_ARB_FIXED_PRIORITY_EN (see alu_arb_rr_picker).
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned N_CORES = NCoresDef,
  parameter int unsigned DATA_W  = DataWDef
) (
  input  logic         CLK,
  input  logic         CPU_Reset,
  alu_arbiter_if.slave bus
);
  localparam int unsigned IdxW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  alu_arb_state_e      state_q, state_d;
  logic [N_CORES-1:0]  win_oh, grant_q, grant_d, done_q, done_d, flag_q, flag_d;
  logic [IdxW-1:0]     win_idx, idx_q, idx_d;
  logic [3:0]          op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
  logic                cmp_en_q, cmp_en_d, advance, cmp_upd;

  alu_arb_rr_picker #(
    .N_CORES (N_CORES),
    .IdxW    (IdxW)
  ) u_picker (
    .clk        (CLK),
    .rst_n      (CPU_Reset),
    .req        (bus.ARB_Req),
    .advance    (advance),
    .winner     (win_oh),
    .winner_idx (win_idx)
  );

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    a_d            = a_q;
    b_d            = b_q;
    cmp_en_d       = cmp_en_q;
    idx_d          = idx_q;
    result_d       = result_q;
    flag_d         = flag_q;
    grant_d        = '0;
    done_d         = '0;
    advance        = 1'b0;
    cmp_upd        = 1'b0;
    bus.ALU_OPCode = '0;
    bus.ALU_A      = '0;
    bus.ALU_B      = '0;
    bus.ALU_CompEn = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|bus.ARB_Req) begin
          advance = 1'b1;
          grant_d = win_oh;
          idx_d   = win_idx;
          state_d = StExec;
          for (int unsigned i = 0; i < N_CORES; i++) begin
            if (win_oh[i]) begin
              op_d     = bus.ARB_OPCode[4*i +: 4];
              a_d      = bus.ARB_A[DATA_W*i +: DATA_W];
              b_d      = bus.ARB_B[DATA_W*i +: DATA_W];
              cmp_en_d = bus.ARB_CmpEn[i];
            end
          end
        end
      end
      StExec: begin
        cmp_upd        = is_compare(op_q) && cmp_en_q;
        bus.ALU_OPCode = op_q;
        bus.ALU_A      = a_q;
        bus.ALU_B      = b_q;
        bus.ALU_CompEn = cmp_upd;
        result_d       = bus.ALU_Result;
        state_d        = StIdle;
        // Only the served core's flag may move; every other bit keeps its value.
        for (int unsigned i = 0; i < N_CORES; i++) begin
          if (idx_q == IdxW'(i)) begin
            done_d[i] = 1'b1;
            if (cmp_upd) flag_d[i] = bus.ALU_Result[0];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge CPU_Reset) begin
    if (!CPU_Reset) begin
      state_q  <= StIdle;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cmp_en_q <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      flag_q   <= '0;
      grant_q  <= '0;
      done_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cmp_en_q <= cmp_en_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      flag_q   <= flag_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
    end
  end

  assign bus.ARB_Grant   = grant_q;
  assign bus.ARB_Done    = done_q;
  assign bus.ARB_Result  = result_q;
  assign bus.ARB_CmpFlag = flag_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, multi-cycle corner sequences, random traffic.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.N_CORES(N), .DATA_W(W)) bus ();

  alu_arbiter #(.N_CORES(N), .DATA_W(W)) dut (
    .CLK       (clk),
    .CPU_Reset (rst_n),
    .bus       (bus)
  );

  function automatic logic [W-1:0] alu_ref(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b);
    case (op)
      OpAnd:   return a & b;
      OpOr:    return a | b;
      OpNot:   return ~a;
      OpXor:   return a ^ b;
      OpShl:   return a << 1;
      OpShr:   return a >> 1;
      OpRol:   return {a[W-2:0], a[W-1]};
      OpRor:   return {a[0], a[W-1:1]};
      OpAdd:   return a + b;
      OpSub:   return a - b;
      OpEq:    return W'(a == b);
      OpGt:    return W'(a > b);
      OpGe:    return W'(a >= b);
      OpNe:    return W'(a != b);
      OpLe:    return W'(a <= b);
      default: return W'(a < b);
    endcase
  endfunction

  // The shared ALU itself lives outside the arbiter.
  always_comb bus.ALU_Result = alu_ref(bus.ALU_OPCode, bus.ALU_A, bus.ALU_B);

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: which core holds the ALU, what it asked for, what came back.
  int           m_ptr;
  bit           m_busy;
  int           m_w;
  logic [3:0]   m_op;
  logic [W-1:0] m_a, m_b, m_res;
  bit           m_cmp;
  logic [N-1:0] m_flag, exp_grant, exp_done;

  task automatic model_reset();
    m_ptr = 0; m_busy = 0; m_w = 0; m_op = '0; m_a = '0; m_b = '0; m_cmp = 0;
    m_res = '0; m_flag = '0; exp_grant = '0; exp_done = '0;
  endtask

  task automatic model_step();
    exp_grant = '0;
    exp_done  = '0;
    if (m_busy) begin
      m_res = alu_ref(m_op, m_a, m_b);
      if (m_cmp && m_op >= 4'd10) m_flag[m_w] = m_res[0];
      exp_done[m_w] = 1'b1;
      m_busy = 0;
    end else if (bus.ARB_Req != '0) begin
      bit found = 0;
      for (int k = 0; k < N; k++) begin
        int c = (m_ptr + k) % N;
        if (!found && bus.ARB_Req[c]) begin
          found = 1;
          m_w = c;
        end
      end
      m_op  = bus.ARB_OPCode[4*m_w +: 4];
      m_a   = bus.ARB_A[W*m_w +: W];
      m_b   = bus.ARB_B[W*m_w +: W];
      m_cmp = bus.ARB_CmpEn[m_w];
      exp_grant[m_w] = 1'b1;
      m_busy = 1;
`ifndef ALU_ARB_FIXED_PRIORITY_EN
      m_ptr = (m_w + 1) % N;
`endif
    end
  endtask

  task automatic check_outputs();
    chk("grant",   bus.ARB_Grant,   exp_grant);
    chk("done",    bus.ARB_Done,    exp_done);
    chk("result",  bus.ARB_Result,  m_res);
    chk("cmpflag", bus.ARB_CmpFlag, m_flag);
    chk("alu_op",  bus.ALU_OPCode,  m_busy ? m_op : 4'h0);
    chk("alu_a",   bus.ALU_A,       m_busy ? m_a : '0);
    chk("alu_b",   bus.ALU_B,       m_busy ? m_b : '0);
    chk("alu_compen", bus.ALU_CompEn, m_busy && m_cmp && (m_op >= 4'd10));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic set_req(int c, logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b, logic cmp);
    bus.ARB_OPCode[4*c +: 4] = op;
    bus.ARB_A[W*c +: W]      = a;
    bus.ARB_B[W*c +: W]      = b;
    bus.ARB_CmpEn[c]         = cmp;
    bus.ARB_Req[c]           = 1'b1;
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_grant"},  bus.ARB_Grant,   '0);
    chk({tag, "_done"},   bus.ARB_Done,    '0);
    chk({tag, "_result"}, bus.ARB_Result,  '0);
    chk({tag, "_flag"},   bus.ARB_CmpFlag, '0);
    chk({tag, "_aluop"},  bus.ALU_OPCode,  '0);
    chk({tag, "_alua"},   bus.ALU_A,       '0);
    chk({tag, "_alub"},   bus.ALU_B,       '0);
    chk({tag, "_compen"}, bus.ALU_CompEn,  '0);
  endtask

  typedef struct {
    int         core;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cmp;
    logic       compen;
    logic [7:0] res;
    logic [3:0] flags;
  } vec_t;

  vec_t tbl[12];
  int   order[5];
  bit   active[N];

  initial begin
    tbl[0]  = '{1, OpAdd, 8'h05, 8'h03, 1'b0, 1'b0, 8'h08, 4'b0000};
    tbl[1]  = '{3, OpRol, 8'h81, 8'h00, 1'b0, 1'b0, 8'h03, 4'b0000};
    tbl[2]  = '{2, OpGt,  8'h09, 8'h04, 1'b1, 1'b1, 8'h01, 4'b0100};
    tbl[3]  = '{2, OpLt,  8'h09, 8'h04, 1'b0, 1'b0, 8'h00, 4'b0100};
    tbl[4]  = '{0, OpEq,  8'h05, 8'h05, 1'b1, 1'b1, 8'h01, 4'b0101};
    tbl[5]  = '{0, OpSub, 8'h10, 8'h01, 1'b0, 1'b0, 8'h0F, 4'b0101};
    tbl[6]  = '{1, OpXor, 8'hF0, 8'hFF, 1'b0, 1'b0, 8'h0F, 4'b0101};
    tbl[7]  = '{3, OpNot, 8'hA5, 8'h00, 1'b0, 1'b0, 8'h5A, 4'b0101};
    tbl[8]  = '{1, OpShr, 8'h81, 8'h00, 1'b0, 1'b0, 8'h40, 4'b0101};
    tbl[9]  = '{2, OpNe,  8'h07, 8'h07, 1'b1, 1'b1, 8'h00, 4'b0001};
    tbl[10] = '{2, OpRor, 8'h01, 8'h00, 1'b1, 1'b0, 8'h80, 4'b0001};
    tbl[11] = '{3, OpGe,  8'h03, 8'h03, 1'b1, 1'b1, 8'h01, 4'b1001};
`ifdef ALU_ARB_FIXED_PRIORITY_EN
    order = '{0, 0, 0, 0, 0};
`else
    order = '{0, 1, 2, 3, 0};
`endif

    bus.ARB_Req = '0; bus.ARB_OPCode = '0; bus.ARB_A = '0; bus.ARB_B = '0; bus.ARB_CmpEn = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    // Directed single-core transactions.
    foreach (tbl[r]) begin
      set_req(tbl[r].core, tbl[r].op, tbl[r].a, tbl[r].b, tbl[r].cmp);
      cycle();
      chk($sformatf("tbl%0d_grant", r), bus.ARB_Grant, 4'b0001 << tbl[r].core);
      chk($sformatf("tbl%0d_compen", r), bus.ALU_CompEn, tbl[r].compen);
      bus.ARB_Req = '0;
      cycle();
      chk($sformatf("tbl%0d_done", r), bus.ARB_Done, 4'b0001 << tbl[r].core);
      chk($sformatf("tbl%0d_result", r), bus.ARB_Result, tbl[r].res);
      chk($sformatf("tbl%0d_flags", r), bus.ARB_CmpFlag, tbl[r].flags);
      chk($sformatf("tbl%0d_compen_off", r), bus.ALU_CompEn, 1'b0);
      cycle();
      chk($sformatf("tbl%0d_hold", r), bus.ARB_Result, tbl[r].res);
    end

    // Reset in the middle of an execute cycle: abandoned, everything clears at once.
    set_req(2, OpAdd, 8'h11, 8'h22, 1'b0);
    cycle();
    bus.ARB_Req = '0;
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // All cores request continuously: pointer restarts from core 0.
    for (int i = 0; i < N; i++) set_req(i, OpAdd, 8'(i * 16), 8'(i + 1), 1'b0);
    for (int j = 0; j < 10; j++) begin
      cycle();
      if (j % 2 == 0) chk($sformatf("all4_grant%0d", j), bus.ARB_Grant, 4'b0001 << order[j/2]);
      else            chk($sformatf("all4_done%0d", j),  bus.ARB_Done,  4'b0001 << order[j/2]);
    end
    bus.ARB_Req = '0;

    // Core 0 raises and drops its request while core 3 owns the ALU.
    set_req(3, OpSub, 8'h40, 8'h01, 1'b0);
    cycle();
    chk("drop_grant3", bus.ARB_Grant, 4'b1000);
    bus.ARB_Req[3] = 1'b0;
    set_req(0, OpAdd, 8'h01, 8'h01, 1'b0);
    cycle();
    chk("drop_done3", bus.ARB_Done, 4'b1000);
    chk("drop_res3", bus.ARB_Result, 8'h3F);
    bus.ARB_Req[0] = 1'b0;
    cycle();
    chk("drop_no_grant0", bus.ARB_Grant, 4'b0000);
    cycle();

    // Random traffic with well-behaved requesters.
    for (int i = 0; i < N; i++) active[i] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++) begin
        if (active[i] && exp_grant[i]) begin
          active[i] = 0;
          bus.ARB_Req[i] = 1'b0;
        end else if (active[i] && $urandom_range(0, 19) == 0) begin
          active[i] = 0;
          bus.ARB_Req[i] = 1'b0;
        end else if (!active[i] && $urandom_range(0, 2) == 0) begin
          active[i] = 1;
          set_req(i, 4'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
        end
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single ALU datapath (ALU_MUX plus adder/subtractor) between the PLC cores of the multicore unit. Each core raises a request with opcode and operands; the block arbitrates, drives the ALU for one execute cycle, captures the result and returns it with a done pulse. Each core keeps a private comparator flag, so compare results never leak between cores. Sits between the core execute stages and the shared ALU.

## Interface
- N_CORES, 4: number of requesting cores (2..8)
- DATA_W, 8: operand/result width; must match ALU
- CLK  in  1  clock, all state on rising edge
- CPU_Reset  in  1  asynchronous, active-low reset
- ARB_Req  in  N_CORES  per-core request level
- ARB_OPCode  in  4*N_CORES  per-core opcode, core i at [4i+3:4i]
- ARB_A, ARB_B  in  DATA_W*N_CORES  per-core operands, packed as opcode
- ARB_CmpEn  in  N_CORES  per-core: update that core's comparator flag
- ARB_Grant  out  N_CORES  one-hot pulse: operands of core i captured
- ARB_Done  out  N_CORES  one-hot pulse: ARB_Result valid for core i
- ARB_Result  out  DATA_W  last captured ALU result, shared by all cores
- ARB_CmpFlag  out  N_CORES  per-core comparator flag
- ALU_OPCode  out  4  to ALU
- ALU_A, ALU_B  out  DATA_W  to ALU
- ALU_CompEn  out  1  to ALU comparator register enable
- ALU_Result  in  DATA_W  from ALU, combinational

## Operation
- FSM states: IDLE, EXEC.
- IDLE: if any ARB_Req bit is set, pick winner w round-robin starting at pointer P. On the edge: latch opcode/A/B of w, set ARB_Grant[w]=1, set P=(w+1) mod N_CORES, go to EXEC. No request: stay in IDLE with all pulses low.
- EXEC: drive ALU_OPCode/A/B from latched registers. ALU_CompEn=1 only if the latched opcode is 1010..1111 and CmpEn[w] was latched high. On the edge: ARB_Result<=ALU_Result, ARB_Done[w]=1, go to IDLE. If the compare condition held, also ARB_CmpFlag[w]<=ALU_Result[0].
- Outside EXEC, ALU_OPCode=4'b0000, ALU_A=ALU_B=0 and ALU_CompEn=0.
- Requester rules: hold Req, opcode and operands stable until its Grant pulse. Req dropped before Grant: no effect. Req still high after Done: treated as a new request.
- ARB_Result holds its value until the next Done. Other cores' CmpFlag bits never change on core w's operation.
- Reset values: state IDLE, P=0, Grant=0, Done=0, Result=0, CmpFlag=0, latched opcode/operands=0.
- Reset mid-EXEC: operation abandoned, no Done. The requester must re-request.

## Timing
- Request seen in IDLE at cycle t: Grant high in cycle t+1 (EXEC), Done and Result valid in cycle t+2.
- Done cycle is IDLE, so back-to-back service is possible. Peak throughput is one op per 2 cycles.
- Worst-case wait with all cores requesting: 2*(N_CORES-1) cycles before own Grant.
- Grant and Done are single-cycle pulses, at most one bit set.
- ALU path is combinational within EXEC. Only registered outputs reach the cores.

## Configuration
- ALU_ARB_FIXED_PRIORITY_EN
  - Defined: fixed priority, lowest index wins. The pointer register is removed and P is treated as constant 0. Starvation of high-index cores is allowed.
  - Undefined (default): round-robin as above.

## Structure
- Package alu_arb_pkg holds:
  - opcode constants: AND, OR, NOT, XOR, SHL, SHR, ROL, ROR, ADD, SUB, EQ, GT, GE, NE, LE, LT
  - IS_COMPARE range constant (1010..1111)
  - FSM state typedef
  - default N_CORES/DATA_W
- Sub-module alu_arb_rr_picker: request vector plus pointer -> one-hot winner and index. Holds the pointer register unless fixed priority is selected.

## Test plan
- Reset then single request: core 1 ADD A=8'h05 B=8'h03 -> Grant[1] at t+1, Done[1] at t+2, Result=8'h08.
- All four cores request continuously -> Grants in order 0,1,2,3,0; each Done two cycles apart; with fixed priority, core 0 only.
- Core 2 GT A=9 B=4 CmpEn=1 -> CmpFlag[2]=1, ALU_CompEn high exactly in EXEC, other flags 0. Core 2 LT with CmpEn=0 -> CmpFlag[2] unchanged.
- Core 0 drops Req before Grant while core 3 is active -> no Grant[0], core 3 served normally.
- CPU_Reset low during EXEC -> no Done, all outputs zero immediately, P=0 after release.
- ROL A=8'h81 from core 3 -> Result=8'h03, held stable through following idle cycles.
